// File: rtl/register_file_pkg.sv
// Shared constants and types for the 32 x 64-bit register file.
// The optional write-to-read forwarding is enabled with REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int RF_WIDTH    = 64;
    localparam int RF_DEPTH    = 32;
    localparam int RF_SEL_W    = 5;
    localparam int RF_ZERO_REG = 31;

    typedef logic [RF_SEL_W-1:0] reg_sel_t;
    typedef logic [RF_WIDTH-1:0] reg_word_t;

endpackage

// File: rtl/register_file_if.sv
// Writeback and operand-fetch bus of the register file.
// The master side is the pipeline; the slave side is the register file.
interface register_file_if
    import regfile_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int SEL_W = RF_SEL_W
);

    logic [WIDTH-1:0] data_in;
    logic [SEL_W-1:0] write_sel;
    logic             write_en;
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;

    modport master (
        output data_in, write_sel, write_en, sel_a, sel_b,
        input  data_a, data_b
    );

    modport slave (
        input  data_in, write_sel, write_en, sel_a, sel_b,
        output data_a, data_b
    );

endinterface

// File: rtl/register_file_cell.sv
// One storage word of the register file: synchronous active-low clear, load-enabled capture.
module regfile_cell
    import regfile_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_file.sv
// Register file: one write port, two combinational read ports, highest register hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a matching read port.
module register_file
    import regfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int SEL_W    = RF_SEL_W,
    parameter int ZERO_REG = RF_ZERO_REG
) (
    input logic            clock,
    input logic            reset,
    register_file_if.slave bus
);

    localparam logic [SEL_W-1:0] ZERO_SEL = SEL_W'(ZERO_REG);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] read_a;
    logic [WIDTH-1:0] read_b;

    // The zero register has no storage; its slot is a constant so the read muxes stay uniform.
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        if (i == ZERO_REG) begin : g_zero
            assign regs[i] = '0;
        end else begin : g_cell
            logic load;
            assign load = bus.write_en & (bus.write_sel == SEL_W'(i));

            regfile_cell #(
                .WIDTH (WIDTH)
            ) u_cell (
                .clock (clock),
                .reset (reset),
                .load  (load),
                .d     (bus.data_in),
                .q     (regs[i])
            );
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd_ok;
    assign fwd_ok = bus.write_en & reset & (bus.write_sel != ZERO_SEL);
`endif

    always_comb begin
        read_a = (bus.sel_a == ZERO_SEL) ? '0 : regs[bus.sel_a];
        read_b = (bus.sel_b == ZERO_SEL) ? '0 : regs[bus.sel_b];
`ifdef REGFILE_BYPASS_EN
        if (fwd_ok && (bus.sel_a == bus.write_sel)) begin
            read_a = bus.data_in;
        end
        if (fwd_ok && (bus.sel_b == bus.write_sel)) begin
            read_b = bus.data_in;
        end
`endif
    end

    assign bus.data_a = read_a;
    assign bus.data_b = read_b;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file with an array-based reference model checked every cycle.
module tb_register_file;
    import regfile_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;

    register_file_if rf_if ();

    register_file dut (
        .clock (clock),
        .reset (reset),
        .bus   (rf_if)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    reg_word_t model [RF_DEPTH];
    bit        model_ok = 1'b0;

    task automatic check(input string name, input reg_word_t act, input reg_word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic reg_word_t model_read(input reg_sel_t sel);
        if (int'(sel) == RF_ZERO_REG) return '0;
`ifdef REGFILE_BYPASS_EN
        if (rf_if.write_en && reset && int'(rf_if.write_sel) != RF_ZERO_REG
            && sel == rf_if.write_sel)
            return rf_if.data_in;
`endif
        return model[sel];
    endfunction

    // Model state advances on the same edge as the DUT; inputs change only #1 later.
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < RF_DEPTH; i++) model[i] = '0;
            model_ok = 1'b1;
        end else if (rf_if.write_en && int'(rf_if.write_sel) != RF_ZERO_REG) begin
            model[rf_if.write_sel] = rf_if.data_in;
        end
    end

    always @(negedge clock) begin
        if (model_ok) begin
            check("model_port_a", rf_if.data_a, model_read(rf_if.sel_a));
            check("model_port_b", rf_if.data_b, model_read(rf_if.sel_b));
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit we, input int ws, input reg_word_t din,
                         input int sa, input int sb);
        rf_if.write_en  = we;
        rf_if.write_sel = reg_sel_t'(ws);
        rf_if.data_in   = din;
        rf_if.sel_a     = reg_sel_t'(sa);
        rf_if.sel_b     = reg_sel_t'(sb);
    endtask

    initial begin
        reg_word_t exp_hz;
        drive(1'b1, 4, 64'h1234, 0, 1);
        reset = 1'b0;

        // 1. Reset for one edge (reset overrides the pending write), then sweep all indices.
        next_cycle();
        reset = 1'b1;
        for (int i = 0; i < RF_DEPTH; i++) begin
            drive(1'b0, 0, '0, i, RF_DEPTH - 1 - i);
            @(negedge clock);
            check("reset_sweep_a", rf_if.data_a, 64'h0);
            check("reset_sweep_b", rf_if.data_b, 64'h0);
            next_cycle();
        end

        // 2. Write r5, read it on both ports next cycle.
        drive(1'b1, 5, 64'hDEAD_BEEF_0000_0001, 0, 0);
        next_cycle();
        drive(1'b0, 0, '0, 5, 5);
        @(negedge clock);
        check("wr_rd_a", rf_if.data_a, 64'hDEAD_BEEF_0000_0001);
        check("wr_rd_b", rf_if.data_b, 64'hDEAD_BEEF_0000_0001);
        next_cycle();

        // 3. Writes to the zero register are dropped.
        drive(1'b1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 31, 31);
        @(negedge clock);
        check("zero_same_cycle", rf_if.data_a, 64'h0);
        next_cycle();
        drive(1'b0, 0, '0, 31, 5);
        @(negedge clock);
        check("zero_after", rf_if.data_a, 64'h0);
        check("zero_r5_intact", rf_if.data_b, 64'hDEAD_BEEF_0000_0001);
        next_cycle();
        for (int i = 0; i < RF_DEPTH; i++) begin
            drive(1'b0, 0, '0, i, i);
            @(negedge clock);
            check("zero_others", rf_if.data_a, (i == 5) ? 64'hDEAD_BEEF_0000_0001 : 64'h0);
            next_cycle();
        end

        // 4. Same-cycle write/read hazard on r7.
        drive(1'b1, 7, 64'h11, 0, 0);
        next_cycle();
        drive(1'b1, 7, 64'h22, 7, 6);
`ifdef REGFILE_BYPASS_EN
        exp_hz = 64'h22;
`else
        exp_hz = 64'h11;
`endif
        @(negedge clock);
        check("hazard_same_cycle", rf_if.data_a, exp_hz);
        check("hazard_other_port", rf_if.data_b, 64'h0);
        next_cycle();
        drive(1'b0, 0, '0, 7, 7);
        @(negedge clock);
        check("hazard_after_a", rf_if.data_a, 64'h22);
        check("hazard_after_b", rf_if.data_b, 64'h22);
        next_cycle();

        // 5. Reset beats a simultaneous write; reads still show pre-edge contents.
        drive(1'b1, 3, 64'hAB, 0, 0);
        next_cycle();
        reset = 1'b0;
        drive(1'b1, 3, 64'h55, 3, 7);
        @(negedge clock);
        check("rst_pre_edge_r3", rf_if.data_a, 64'hAB);
        check("rst_pre_edge_r7", rf_if.data_b, 64'h22);
        next_cycle();
        reset = 1'b1;
        drive(1'b0, 0, '0, 3, 7);
        @(negedge clock);
        check("rst_vs_write_r3", rf_if.data_a, 64'h0);
        check("rst_vs_write_r7", rf_if.data_b, 64'h0);
        next_cycle();

        // 6. Fill r0..r30 with i*3, then random reads with occasional writes.
        for (int i = 0; i < RF_DEPTH - 1; i++) begin
            drive(1'b1, i, reg_word_t'(i * 3), i, 31);
            next_cycle();
        end
        drive(1'b0, 0, '0, 30, 10);
        @(negedge clock);
        check("fill_r30", rf_if.data_a, 64'd90);
        check("fill_r10", rf_if.data_b, 64'd30);
        next_cycle();
        for (int n = 0; n < 200; n++) begin
            drive(($urandom_range(0, 3) == 0), int'($urandom_range(0, 31)),
                  {$urandom, $urandom}, int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)));
            next_cycle();
        end
        drive(1'b0, 0, '0, 0, 0);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
